// File: rtl/rd_byte_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rd_byte_packer_pkg
// Brief    : Shared types and constants for the read-path byte packer.
// Revision : 1.0 - initial release
// ============================================================================
package rd_byte_packer_pkg;

    // Bits per packed byte on the serial read pipe
    localparam int unsigned BYTE_BITS = 8;

    // Packer transfer status
    typedef enum logic [1:0] {
        PIDLE    = 2'd0,
        PCOLLECT = 2'd1,
        PDONE    = 2'd2
    } pstatus_t;

endpackage : rd_byte_packer_pkg
`default_nettype wire

// File: rtl/sync_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_byte_fifo
// Brief    : Single-clock show-ahead FIFO; the head entry is presented on
//            o_rd_data whenever o_empty is low, zero otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module sync_byte_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_do_wr   = i_wr_en && !o_full;
    assign w_do_rd   = i_rd_en && !o_empty;
    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents need no reset because o_empty masks the head
    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_byte_fifo
`default_nettype wire

// File: rtl/rd_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : rd_byte_packer
// Brief    : Packs the MSB-first serial read pipe into bytes, queues them in
//            a show-ahead FIFO and presents a valid/ready byte stream with a
//            last tag, byte count and sticky overrun/fragment flags.
// Revision : 1.0 - initial release
// ============================================================================
module rd_byte_packer
    import rd_byte_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 24
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             exec_rd,
    input  logic [LEN_W-1:0] exec_rd_len,
    input  logic             exec_rd_finish,
    input  logic             rpipe_vld,
    output logic             rpipe_ready,
    input  logic             rpipe_data,
    output logic             m_vld,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [LEN_W-1:0] byte_cnt,
    output logic             overrun,
    output logic             frag_err,
    input  logic             err_clr
);

    localparam logic [LEN_W-1:0] c_CNT_MAX = '1;
    localparam logic [2:0]       c_BIT_LAST = 3'(BYTE_BITS - 1);

    pstatus_t               r_state;
    pstatus_t               w_state_nxt;
    logic                   r_exec_rd_d;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_byte_cnt;
    logic [2:0]             r_bit_cnt;
    logic [BYTE_BITS-2:0]   r_shift;
    logic                   r_overrun;
    logic                   r_frag_err;

    logic                   w_rise;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_last_tag;
    logic                   w_finish_collect;
    logic                   w_overrun_set;
    logic                   w_frag_set;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [BYTE_BITS:0]     w_fifo_rd;

    assign w_rise   = exec_rd && !r_exec_rd_d;
    // Hold off only the byte-completing bit when there is nowhere to put it
    assign w_ready  = (r_state == PCOLLECT) && !((r_bit_cnt == c_BIT_LAST) && w_fifo_full);
    assign w_accept = rpipe_vld && w_ready;
    assign w_push   = w_accept && (r_bit_cnt == c_BIT_LAST);
    // A zero length never matches, so no byte of an illegal transfer is tagged
    assign w_last_tag = (r_len != '0) && (r_byte_cnt == (r_len - LEN_W'(1)));
    assign w_finish_collect = exec_rd_finish && (r_state == PCOLLECT);

    assign w_overrun_set = rpipe_vld && !w_ready &&
                           ((r_state == PCOLLECT) || (r_state == PDONE));
    assign w_frag_set    = w_finish_collect &&
                           ((r_bit_cnt != '0) || (r_byte_cnt < r_len) || (r_len == '0));

    // Next-state selection; dropping exec_rd aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        if (!exec_rd) begin
            w_state_nxt = PIDLE;
        end else begin
            case (r_state)
                PIDLE: begin
                    if (w_rise) begin
                        w_state_nxt = PCOLLECT;
                    end
                end
                PCOLLECT: begin
                    if (exec_rd_finish) begin
                        w_state_nxt = PIDLE;
                    end else if (w_push && w_last_tag) begin
                        w_state_nxt = PDONE;
                    end
                end
                PDONE: begin
                    if (exec_rd_finish) begin
                        w_state_nxt = PIDLE;
                    end
                end
                default: w_state_nxt = PIDLE;
            endcase
        end
    end

    // State register and exec_rd edge history
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state     <= PIDLE;
            r_exec_rd_d <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exec_rd_d <= exec_rd;
        end
    end

    // Shift register, bit/byte counters and latched transfer length
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if ((r_state == PIDLE) && w_rise) begin
            r_len      <= exec_rd_len;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            if (w_accept) begin
                r_shift   <= {r_shift[BYTE_BITS-3:0], rpipe_data};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_push && (r_byte_cnt != c_CNT_MAX)) begin
                    r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                end
            end
            // A finished transfer throws away any partially shifted byte
            if (w_finish_collect) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end
        end
    end

    // Sticky error flags; a new error outranks a clear in the same cycle
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_overrun  <= 1'b0;
            r_frag_err <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_frag_set) begin
                r_frag_err <= 1'b1;
            end else if (err_clr) begin
                r_frag_err <= 1'b0;
            end
        end
    end

    sync_byte_fifo #(
        .WIDTH (BYTE_BITS + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .i_wr_en   (w_push),
        .i_wr_data ({r_shift, rpipe_data, w_last_tag}),
        .i_rd_en   (m_vld && m_ready),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign rpipe_ready = w_ready;
    assign m_vld       = !w_fifo_empty;
    assign m_data      = w_fifo_rd[BYTE_BITS:1];
    assign m_last      = w_fifo_rd[0];
    assign byte_cnt    = r_byte_cnt;
    assign overrun     = r_overrun;
    assign frag_err    = r_frag_err;

endmodule : rd_byte_packer
`default_nettype wire

// File: tb/tb_rd_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_byte_packer
// Brief    : Self-checking bench for rd_byte_packer: table-driven transfers,
//            hand-written corner sequences and randomized transfers against
//            a queue-based expected byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_byte_packer;
    import rd_byte_packer_pkg::*;

    localparam int DEPTH = 2;
    localparam int LEN_W = 24;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             exec_rd;
    logic [LEN_W-1:0] exec_rd_len;
    logic             exec_rd_finish;
    logic             rpipe_vld;
    logic             rpipe_ready;
    logic             rpipe_data;
    logic             m_vld;
    logic             m_ready;
    logic [7:0]       m_data;
    logic             m_last;
    logic [LEN_W-1:0] byte_cnt;
    logic             overrun;
    logic             frag_err;
    logic             err_clr;

    int n_cmp  = 0;
    int n_fail = 0;
    bit rnd_mready = 1'b0;
    logic [8:0] cap_q [$];
    logic [8:0] exp_q [$];

    typedef struct {
        int         len;
        int         nb;
        logic [7:0] b [3];
        int         exp_cnt;
    } vec_t;
    vec_t tbl [3];

    rd_byte_packer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .exec_rd        (exec_rd),
        .exec_rd_len    (exec_rd_len),
        .exec_rd_finish (exec_rd_finish),
        .rpipe_vld      (rpipe_vld),
        .rpipe_ready    (rpipe_ready),
        .rpipe_data     (rpipe_data),
        .m_vld          (m_vld),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .byte_cnt       (byte_cnt),
        .overrun        (overrun),
        .frag_err       (frag_err),
        .err_clr        (err_clr)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    // One clock: record any byte handed over at this edge, then settle
    task automatic tick();
        if (rnd_mready) m_ready = 1'($urandom_range(0, 1));
        if (m_vld && m_ready) cap_q.push_back({m_data, m_last});
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int k;
        rpipe_vld = 1'b0;
        k = 0;
        while (!rpipe_ready && k < 200) begin
            tick();
            k++;
        end
        chk("rpipe_ready_wait", {31'd0, rpipe_ready}, 32'd1);
        rpipe_vld  = 1'b1;
        rpipe_data = b;
        tick();
        rpipe_vld  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic start_xfer(input int len);
        exec_rd = 1'b0;
        tick();
        exec_rd_len = LEN_W'(len);
        exec_rd = 1'b1;
        tick();
    endtask

    task automatic end_xfer();
        exec_rd_finish = 1'b1;
        tick();
        exec_rd_finish = 1'b0;
        exec_rd = 1'b0;
        tick();
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!m_vld) break;
            tick();
        end
    endtask

    task automatic check_stream(input string name);
        chk({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk({name, "_data"}, {24'd0, cap_q[i][8:1]}, {24'd0, exp_q[i][8:1]});
            chk({name, "_last"}, {31'd0, cap_q[i][0]}, {31'd0, exp_q[i][0]});
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_rpipe_ready"}, {31'd0, rpipe_ready}, 32'd0);
        chk({name, "_m_vld"},       {31'd0, m_vld},       32'd0);
        chk({name, "_m_data"},      {24'd0, m_data},      32'd0);
        chk({name, "_m_last"},      {31'd0, m_last},      32'd0);
        chk({name, "_byte_cnt"},    {8'd0, byte_cnt},     32'd0);
        chk({name, "_overrun"},     {31'd0, overrun},     32'd0);
        chk({name, "_frag_err"},    {31'd0, frag_err},    32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        int rlen;

        tbl[0].len = 1; tbl[0].nb = 1; tbl[0].exp_cnt = 1;
        tbl[0].b[0] = 8'hA5; tbl[0].b[1] = 8'h00; tbl[0].b[2] = 8'h00;
        tbl[1].len = 3; tbl[1].nb = 3; tbl[1].exp_cnt = 3;
        tbl[1].b[0] = 8'h01; tbl[1].b[1] = 8'h80; tbl[1].b[2] = 8'hFF;
        tbl[2].len = 2; tbl[2].nb = 2; tbl[2].exp_cnt = 2;
        tbl[2].b[0] = 8'h5A; tbl[2].b[1] = 8'hC3; tbl[2].b[2] = 8'h00;

        rst_n = 1'b0; exec_rd = 1'b0; exec_rd_len = '0; exec_rd_finish = 1'b0;
        rpipe_vld = 1'b0; rpipe_data = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Table-driven complete transfers
        for (int t = 0; t < 3; t++) begin
            cap_q.delete(); exp_q.delete();
            m_ready = 1'b1;
            start_xfer(tbl[t].len);
            for (int j = 0; j < tbl[t].nb; j++) begin
                send_byte(tbl[t].b[j]);
                chk("tbl_m_vld_after_8th", {31'd0, m_vld}, 32'd1);
                exp_q.push_back({tbl[t].b[j], (j == tbl[t].len - 1)});
            end
            drain();
            check_stream("tbl_stream");
            chk("tbl_byte_cnt", {8'd0, byte_cnt}, 32'(tbl[t].exp_cnt));
            chk("tbl_state_done", 32'(dut.r_state), 32'(PDONE));
            chk("tbl_rpipe_ready_done", {31'd0, rpipe_ready}, 32'd0);
            chk("tbl_overrun", {31'd0, overrun}, 32'd0);
            chk("tbl_frag_err", {31'd0, frag_err}, 32'd0);
            end_xfer();
            chk("tbl_state_idle", 32'(dut.r_state), 32'(PIDLE));
        end

        // Backpressure with full FIFO and an overrun on the blocked bit
        m_ready = 1'b0;
        start_xfer(3);
        send_byte(8'h01);
        send_byte(8'h80);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("bp_rpipe_ready_low", {31'd0, rpipe_ready}, 32'd0);
        chk("bp_m_vld", {31'd0, m_vld}, 32'd1);
        rpipe_vld = 1'b1; rpipe_data = 1'b1;
        tick();
        rpipe_vld = 1'b0;
        chk("bp_overrun", {31'd0, overrun}, 32'd1);
        chk("bp_byte_cnt", {8'd0, byte_cnt}, 32'd2);
        exp_q.push_back({8'h01, 1'b0});
        exp_q.push_back({8'h80, 1'b0});
        drain();
        check_stream("bp_drain");
        send_bit(1'b1);
        drain();
        exp_q.push_back({8'hFF, 1'b1});
        check_stream("bp_final");
        chk("bp_state_done", 32'(dut.r_state), 32'(PDONE));
        end_xfer();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("bp_overrun_cleared", {31'd0, overrun}, 32'd0);

        // Fragment: finish after 12 of 16 bits
        m_ready = 1'b0;
        start_xfer(2);
        send_byte(8'h96);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("frag_m_vld", {31'd0, m_vld}, 32'd1);
        chk("frag_m_data", {24'd0, m_data}, 32'h96);
        chk("frag_m_last", {31'd0, m_last}, 32'd0);
        exec_rd_finish = 1'b1;
        tick();
        exec_rd_finish = 1'b0;
        chk("frag_err_set", {31'd0, frag_err}, 32'd1);
        chk("frag_state_idle", 32'(dut.r_state), 32'(PIDLE));
        chk("frag_bits_discarded", {29'd0, dut.r_bit_cnt}, 32'd0);
        exec_rd = 1'b0;
        drain();
        exp_q.push_back({8'h96, 1'b0});
        check_stream("frag_drain");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("frag_err_cleared", {31'd0, frag_err}, 32'd0);

        // Illegal zero length: nothing tagged last, fragment at finish
        m_ready = 1'b1;
        start_xfer(0);
        send_byte(8'h77);
        drain();
        exp_q.push_back({8'h77, 1'b0});
        check_stream("len0_stream");
        chk("len0_state_collect", 32'(dut.r_state), 32'(PCOLLECT));
        end_xfer();
        chk("len0_frag_err", {31'd0, frag_err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset in the middle of a byte with one byte queued
        m_ready = 1'b0;
        start_xfer(2);
        send_byte(8'h11);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("mid_m_vld_before_reset", {31'd0, m_vld}, 32'd1);
        rst_n = 1'b0; exec_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_vals("mid_reset");
        m_ready = 1'b1;
        start_xfer(1);
        send_byte(8'h3C);
        drain();
        exp_q.push_back({8'h3C, 1'b1});
        check_stream("post_reset_stream");
        chk("post_reset_byte_cnt", {8'd0, byte_cnt}, 32'd1);
        chk("post_reset_state_done", 32'(dut.r_state), 32'(PDONE));

        // Overrun set and clear in the same cycle: set wins
        rpipe_vld = 1'b1; err_clr = 1'b1;
        tick();
        chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
        rpipe_vld = 1'b0;
        tick();
        chk("ovr_clr_alone", {31'd0, overrun}, 32'd0);
        err_clr = 1'b0;
        end_xfer();

        // Randomized transfers with random gaps and random consumer stalls
        for (int t = 0; t < 30; t++) begin
            cap_q.delete(); exp_q.delete();
            rlen = int'($urandom_range(1, 6));
            rnd_mready = 1'b1;
            start_xfer(rlen);
            for (int j = 0; j < rlen; j++) begin
                rb = 8'($urandom);
                exp_q.push_back({rb, (j == rlen - 1)});
                for (int i = 7; i >= 0; i--) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_bit(rb[i]);
                end
            end
            rnd_mready = 1'b0;
            drain();
            check_stream("rnd_stream");
            chk("rnd_byte_cnt", {8'd0, byte_cnt}, 32'(rlen));
            chk("rnd_overrun", {31'd0, overrun}, 32'd0);
            chk("rnd_frag_err", {31'd0, frag_err}, 32'd0);
            end_xfer();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rd_byte_packer
`default_nettype wire
